// File: rtl/divider16_pkg.sv
// rtl/divider16_pkg.sv - shared ALU divider types: state encoding, width defaults, status bit indices
package divider16_pkg;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_INSTR_W = 16;

  // Bit positions inside div_status; the multiplier's mul_status uses the same layout
  localparam int STATUS_BUSY = 1;
  localparam int STATUS_DONE = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/divider16_div_step.sv
// rtl/divider16_div_step.sv - one combinational radix-2 restoring division iteration
module divider16_div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_r,
  input  logic         i_a_msb,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r_next,
  output logic         o_q_bit
);
  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // The partial remainder is always below B, so a W+1-bit difference cannot
  // overflow and its top bit is exactly the borrow (shifted value < B).
  assign w_shift  = {i_r, i_a_msb};
  assign w_diff   = w_shift - {1'b0, i_b};
  assign o_q_bit  = ~w_diff[W];
  assign o_r_next = o_q_bit ? w_diff[W-1:0] : w_shift[W-1:0];
endmodule

// File: rtl/divider16.sv
// rtl/divider16.sv - iterative restoring unsigned divider, one quotient bit per cycle
module divider16
  import divider16_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [1:0]         div_status,
  output logic [INSTR_W-1:0] ex_instr_out
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_t         r_state;
  div_state_t         w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_part;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic [INSTR_W-1:0] r_tag;
  logic [WIDTH-1:0]   w_part_next;
  logic               w_q_bit;
  logic               w_accept;
  logic               w_last;

  divider16_div_step #(.W(WIDTH)) u_step (
    .i_r      (r_part),
    .i_a_msb  (r_dividend[WIDTH-1]),
    .i_b      (r_divisor),
    .o_r_next (w_part_next),
    .o_q_bit  (w_q_bit)
  );

  assign ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = ready && (instr != '0);
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_next_state = (B == '0) ? ST_DONE : ST_RUN;
        else          w_next_state = ST_IDLE;
      end
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Quotient bits shift into the dividend register as its bits shift out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_part      <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_tag       <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_dividend <= A;
        r_divisor  <= B;
        r_tag      <= instr;
        r_part     <= '0;
        r_count    <= '0;
        if (B == '0) begin
          r_quotient  <= '1;
          r_remainder <= A;
        end
      end else if (r_state == ST_RUN) begin
        r_dividend <= {r_dividend[WIDTH-2:0], w_q_bit};
        r_part     <= w_part_next;
        r_count    <= r_count + CNT_W'(1);
        if (w_last) begin
          r_quotient  <= {r_dividend[WIDTH-2:0], w_q_bit};
          r_remainder <= w_part_next;
        end
      end
    end
  end

  assign quotient                = r_quotient;
  assign remainder               = r_remainder;
  assign div_status[STATUS_BUSY] = (r_state == ST_RUN);
  assign div_status[STATUS_DONE] = (r_state == ST_DONE);
  assign ex_instr_out            = (r_state == ST_DONE) ? r_tag : '0;
endmodule

// File: tb/tb_divider16.sv
// tb/tb_divider16.sv - scoreboard bench for divider16 with directed and randomized divides
module tb_divider16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic [1:0]  div_status;
  logic [15:0] ex_instr_out;

  divider16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .A            (A),
    .B            (B),
    .ready        (ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_status   (div_status),
    .ex_instr_out (ex_instr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tag;
    logic [15:0] q;
    logic [15:0] r;
    logic [15:0] b;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] hold_q = '0;
  logic [15:0] hold_r = '0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops one expected result per done cycle; otherwise results must hold
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_eq_not_busy", {31'd0, ready}, {31'd0, !div_status[1]});
      if (div_status[0]) begin
        if (sb.size() == 0) begin
          flag("unexpected_done");
        end else begin
          mon_e = sb.pop_front();
          check("quotient", {16'd0, quotient}, {16'd0, mon_e.q});
          check("remainder", {16'd0, remainder}, {16'd0, remainder === remainder ? mon_e.r : 16'hx});
          check("ex_instr_out", {16'd0, ex_instr_out}, {16'd0, mon_e.tag});
          check("done_latency", cyc, mon_e.cyc);
          if (prev_done && mon_e.b != 16'd0) flag("done_wider_than_one_cycle");
          hold_q = mon_e.q;
          hold_r = mon_e.r;
        end
      end else begin
        check("tag_zero_outside_done", {16'd0, ex_instr_out}, 32'd0);
        check("quotient_hold", {16'd0, quotient}, {16'd0, hold_q});
        check("remainder_hold", {16'd0, remainder}, {16'd0, hold_r});
      end
      prev_done = div_status[0];
    end else begin
      prev_done = 1'b0;
      hold_q = '0;
      hold_r = '0;
    end
  end

  // Called at a negedge; holds the request until ready, then records the expectation
  task automatic send(input logic [15:0] t, input logic [15:0] a, input logic [15:0] b);
    int   g = 0;
    exp_t e;
    instr = t;
    A = a;
    B = b;
    while (!ready && g < 64) begin
      @(negedge clk);
      g++;
    end
    if (g >= 64) begin
      flag("accept_timeout");
    end else begin
      e.tag = t;
      e.b   = b;
      e.q   = (b == 16'd0) ? 16'hFFFF : a / b;
      e.r   = (b == 16'd0) ? a : a % b;
      e.cyc = cyc + 1 + ((b == 16'd0) ? 0 : 16);
      sb.push_back(e);
    end
    @(negedge clk);
    instr = '0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      flag("drain_timeout");
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] t;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_status", {30'd0, div_status}, 32'd0);
    check("reset_quotient", {16'd0, quotient}, 32'd0);
    check("reset_remainder", {16'd0, remainder}, 32'd0);
    check("reset_tag", {16'd0, ex_instr_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h1234, 16'd100, 16'd7);
    drain();
    send(16'h0001, 16'hFFFF, 16'd1);
    send(16'h0002, 16'd3, 16'd10);
    send(16'h0003, 16'd5, 16'd0);
    drain();
    // Second request is held through the first op's RUN and must land in its DONE cycle
    send(16'h0004, 16'd1000, 16'd9);
    send(16'h0005, 16'd60000, 16'd255);
    send(16'h0006, 16'd7, 16'd0);
    send(16'h0007, 16'd9, 16'd0);
    drain();

    send(16'h0008, 16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrun_reset_ready", {31'd0, ready}, 32'd1);
    check("midrun_reset_status", {30'd0, div_status}, 32'd0);
    check("midrun_reset_quotient", {16'd0, quotient}, 32'd0);
    check("midrun_reset_remainder", {16'd0, remainder}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1, 2:    b = 16'($urandom_range(1, 15));
        3:       b = 16'($urandom_range(32768, 65535));
        default: b = 16'($urandom);
      endcase
      t = 16'($urandom_range(1, 65535));
      send(t, a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
